// File: rtl/logic_gates_pkg.sv
// Shared constants for the logic-gate cell library.
package logic_gates_pkg;

   localparam int unsigned GATE_WIDTH_DEF = 1;
   localparam int unsigned GATE_WIDTH_MAX = 64;

endpackage

// File: rtl/or_gate_reg_stage.sv
// WIDTH-wide load-enable register with asynchronous active-low clear.
module or_gate_reg_stage #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/or_gate_unit.sv
// Bitwise two-input OR cell with combinational output, optional registered
// copy with valid, reduction flag and a sticky OR accumulator.
module or_gate_unit
   import logic_gates_pkg::*;
#(
   parameter int unsigned WIDTH   = GATE_WIDTH_DEF,
   parameter bit          REG_OUT = 1'b1
) (
   input  logic             _clk,
   input  logic             _rst_n,
   input  logic [WIDTH-1:0] _a,
   input  logic [WIDTH-1:0] _b,
   output logic [WIDTH-1:0] _y0,
   input  logic             _in_valid,
   output logic [WIDTH-1:0] _y0_q,
   output logic             _out_valid,
   output logic             _y0_any,
   input  logic             _acc_clr,
   output logic [WIDTH-1:0] _acc
);

   logic [WIDTH-1:0] or_val;
   logic [WIDTH-1:0] acc_next;
   logic             acc_en;

   assign or_val  = _a | _b;
   assign _y0     = or_val;
   assign _y0_any = |or_val;

   // Clear wins over a simultaneous valid result
   always_comb begin
      acc_en   = _acc_clr | _in_valid;
      acc_next = _acc_clr ? '0 : (_acc | or_val);
   end

   or_gate_reg_stage #(.WIDTH(WIDTH)) u_acc (
      .clk   (_clk),
      .rst_n (_rst_n),
      .en    (acc_en),
      .d     (acc_next),
      .q     (_acc)
   );

   generate
      if (REG_OUT) begin : g_reg
         or_gate_reg_stage #(.WIDTH(WIDTH)) u_y0_q (
            .clk   (_clk),
            .rst_n (_rst_n),
            .en    (_in_valid),
            .d     (or_val),
            .q     (_y0_q)
         );

         always_ff @(posedge _clk or negedge _rst_n) begin
            if (!_rst_n) begin
               _out_valid <= 1'b0;
            end else begin
               _out_valid <= _in_valid;
            end
         end
      end else begin : g_comb
         assign _y0_q      = or_val;
         assign _out_valid = _in_valid;
      end
   endgenerate

endmodule

// File: tb/tb_or_gate_unit.sv
// Self-checking bench for or_gate_unit: directed vector table, no-clock
// WIDTH=1 sequence, reset corner cases and randomized model comparison.
module tb_or_gate_unit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] a, b;
   logic       in_valid, acc_clr;
   logic [7:0] y0, y0_q, acc;
   logic       out_valid, y0_any;

   logic [7:0] nr_y0, nr_y0_q, nr_acc;
   logic       nr_out_valid, nr_y0_any;

   logic       clk1 = 1'b0;
   logic       rst1;
   logic [0:0] a1, b1, y01, q1, acc1;
   logic       ov1, any1;
   logic       w1_done = 1'b0;

   int unsigned total = 0;
   int unsigned passed = 0;

   always #5 clk = ~clk;

   or_gate_unit #(.WIDTH(8), .REG_OUT(1'b1)) u_dut (
      ._clk(clk), ._rst_n(rst_n), ._a(a), ._b(b), ._y0(y0),
      ._in_valid(in_valid), ._y0_q(y0_q), ._out_valid(out_valid),
      ._y0_any(y0_any), ._acc_clr(acc_clr), ._acc(acc)
   );

   or_gate_unit #(.WIDTH(8), .REG_OUT(1'b0)) u_nr (
      ._clk(clk), ._rst_n(rst_n), ._a(a), ._b(b), ._y0(nr_y0),
      ._in_valid(in_valid), ._y0_q(nr_y0_q), ._out_valid(nr_out_valid),
      ._y0_any(nr_y0_any), ._acc_clr(acc_clr), ._acc(nr_acc)
   );

   or_gate_unit #(.WIDTH(1), .REG_OUT(1'b1)) u_w1 (
      ._clk(clk1), ._rst_n(rst1), ._a(a1), ._b(b1), ._y0(y01),
      ._in_valid(1'b0), ._y0_q(q1), ._out_valid(ov1),
      ._y0_any(any1), ._acc_clr(1'b0), ._acc(acc1)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   typedef struct {
      logic [7:0] a, b;
      logic       valid, clr;
      logic [7:0] e_y0;
      logic       e_any;
      logic [7:0] e_q;
      logic       e_ov;
      logic [7:0] e_acc;
   } vec_t;

   // WIDTH=1, clock never runs: a toggles every 2 ns, b every 4 ns
   initial begin
      logic [3:0] exp_w1;
      exp_w1 = 4'b1011;  // index 0..3 -> 1,1,0,1
      rst1 = 1'b1;
      for (int k = 0; k < 25; k++) begin
         a1 = 1'(k % 2);
         b1 = 1'(((k / 2) % 2) == 0);
         #1;
         chk("w1_y0", 64'(y01), 64'(exp_w1[k % 4]));
         chk("w1_any", 64'(any1), 64'(exp_w1[k % 4]));
         #1;
      end
      w1_done = 1'b1;
   end

   initial begin
      vec_t       vecs[7];
      logic [7:0] m_q, m_acc, e;
      logic       m_ov;

      vecs[0] = '{8'hA0, 8'h05, 1'b1, 1'b0, 8'hA5, 1'b1, 8'hA5, 1'b1, 8'hA5};
      vecs[1] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'hA5, 1'b0, 8'hA5};
      vecs[2] = '{8'h80, 8'h00, 1'b0, 1'b1, 8'h80, 1'b1, 8'hA5, 1'b0, 8'h00};
      vecs[3] = '{8'h01, 8'h00, 1'b1, 1'b0, 8'h01, 1'b1, 8'h01, 1'b1, 8'h01};
      vecs[4] = '{8'h10, 8'h02, 1'b1, 1'b0, 8'h12, 1'b1, 8'h12, 1'b1, 8'h13};
      vecs[5] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h13};
      vecs[6] = '{8'hFF, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 8'hFF, 1'b1, 8'h00};

      rst_n = 1'b1; a = '0; b = '0; in_valid = 1'b0; acc_clr = 1'b0;
      #1 rst_n = 1'b0;
      #5;
      chk("rst_q", 64'(y0_q), 64'h0);
      chk("rst_ov", 64'(out_valid), 64'h0);
      chk("rst_acc", 64'(acc), 64'h0);
      chk("rst_nr_acc", 64'(nr_acc), 64'h0);
      @(negedge clk) rst_n = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clk);
         a = vecs[i].a; b = vecs[i].b; in_valid = vecs[i].valid; acc_clr = vecs[i].clr;
         #1;
         chk($sformatf("v%0d_y0", i), 64'(y0), 64'(vecs[i].e_y0));
         chk($sformatf("v%0d_any", i), 64'(y0_any), 64'(vecs[i].e_any));
         chk($sformatf("v%0d_nr_q", i), 64'(nr_y0_q), 64'(vecs[i].e_y0));
         chk($sformatf("v%0d_nr_ov", i), 64'(nr_out_valid), 64'(vecs[i].valid));
         @(posedge clk); #1;
         chk($sformatf("v%0d_q", i), 64'(y0_q), 64'(vecs[i].e_q));
         chk($sformatf("v%0d_ov", i), 64'(out_valid), 64'(vecs[i].e_ov));
         chk($sformatf("v%0d_acc", i), 64'(acc), 64'(vecs[i].e_acc));
         chk($sformatf("v%0d_nr_acc", i), 64'(nr_acc), 64'(vecs[i].e_acc));
      end

      m_q = 8'hFF; m_ov = 1'b1; m_acc = 8'h00;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         a = 8'($urandom); b = 8'($urandom);
         in_valid = 1'($urandom_range(0, 1));
         acc_clr = ($urandom_range(0, 7) == 0);
         e = a | b;
         #1;
         chk("rnd_y0", 64'(y0), 64'(e));
         chk("rnd_any", 64'(y0_any), 64'(e != 8'h00));
         chk("rnd_nr_q", 64'(nr_y0_q), 64'(e));
         if (in_valid) m_q = e;
         m_ov = in_valid;
         if (acc_clr) m_acc = 8'h00;
         else if (in_valid) m_acc = m_acc | e;
         @(posedge clk); #1;
         chk("rnd_q", 64'(y0_q), 64'(m_q));
         chk("rnd_ov", 64'(out_valid), 64'(m_ov));
         chk("rnd_acc", 64'(acc), 64'(m_acc));
         chk("rnd_nr_acc", 64'(nr_acc), 64'(m_acc));
      end

      // Asynchronous reset in the middle of a cycle
      @(negedge clk);
      a = 8'hFF; b = 8'h00; in_valid = 1'b1; acc_clr = 1'b0;
      @(posedge clk); #1;
      chk("pre_rst_acc", 64'(acc), 64'hFF);
      chk("pre_rst_ov", 64'(out_valid), 64'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_q", 64'(y0_q), 64'h0);
      chk("mid_rst_ov", 64'(out_valid), 64'h0);
      chk("mid_rst_acc", 64'(acc), 64'h0);
      chk("mid_rst_nr_acc", 64'(nr_acc), 64'h0);
      a = 8'h3C; b = 8'h41;
      #1;
      chk("rst_y0_track", 64'(y0), 64'h7D);
      chk("rst_any_track", 64'(y0_any), 64'h1);
      @(posedge clk); #1;
      chk("rst_hold_q", 64'(y0_q), 64'h0);
      chk("rst_hold_ov", 64'(out_valid), 64'h0);
      chk("rst_hold_acc", 64'(acc), 64'h0);
      @(negedge clk);
      rst_n = 1'b1; a = 8'h11; b = 8'h00;
      @(posedge clk); #1;
      chk("post_rst_q", 64'(y0_q), 64'h11);
      chk("post_rst_ov", 64'(out_valid), 64'h1);
      chk("post_rst_acc", 64'(acc), 64'h11);

      if (!w1_done) chk("w1_done", 64'(w1_done), 64'h1);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
